// File: rtl/dma_dev_agent_pkg.sv
// Shared types and constants for the DMA device-side agent.
// FSM state codes, error codes and a config validity helper.
package dma_dev_agent_pkg;

    localparam int ADD_LEN_DEF  = 16;
    localparam int DATA_LEN_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_REQ   = 3'd2,
        ST_XFER  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CFG     = 2'b01;
    localparam logic [1:0] ERR_SHORT   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // Odd byte address or an empty transfer cannot be issued.
    function automatic logic cfg_invalid(input logic addr_lsb, input logic words_zero);
        return addr_lsb | words_zero;
    endfunction

endpackage

// File: rtl/dma_dev_agent_fifo.sv
// Small synchronous FIFO buffering words between the DMA controller and the peripheral.
// Push while full is accepted only together with a pop; flush empties it in one cycle.
module dma_dev_agent_fifo #(
    parameter int DATA_W  = 16,
    parameter int DEPTH_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [DEPTH_W:0]  used_o
);
    localparam int ENTRIES = 1 << DEPTH_W;

    logic [DATA_W-1:0]  mem_q [ENTRIES];
    logic [DEPTH_W-1:0] wr_ptr_q;
    logic [DEPTH_W-1:0] rd_ptr_q;
    logic [DEPTH_W:0]   used_q;
    logic               do_push_s;
    logic               do_pop_s;

    assign empty_o   = (used_q == (DEPTH_W+1)'(0));
    assign full_o    = (used_q == (DEPTH_W+1)'(ENTRIES));
    assign used_o    = used_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   used_q <= used_q + (DEPTH_W+1)'(1);
                2'b01:   used_q <= used_q - (DEPTH_W+1)'(1);
                default: used_q <= used_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, reads are gated by empty.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/dma_dev_agent.sv
// Device-side endpoint of the DMA device interface: requests one transfer per cfg_start
// and streams words between the controller and the peripheral's local ports.
module dma_dev_agent
    import dma_dev_agent_pkg::*;
#(
    parameter int ADD_LEN   = 16,
    parameter int DATA_LEN  = 16,
    parameter int BUF_DEPTH = 2,
    parameter int TIMEOUT_W = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_start,
    input  logic                cfg_rd_wr,
    input  logic [ADD_LEN:0]    cfg_addr,
    input  logic [ADD_LEN-1:0]  cfg_words,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [DATA_LEN-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    input  logic [DATA_LEN-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                rqst,
    output logic                rd_wr,
    output logic [ADD_LEN:0]    start_addr,
    output logic [ADD_LEN-1:0]  num_words,
    output logic                dev_ack,
    output logic [DATA_LEN-1:0] dev_in,
    input  logic                dma_ack,
    input  logic [DATA_LEN-1:0] dev_out,
    input  logic                end_flag
);
    localparam int ENTRIES = 1 << BUF_DEPTH;

    state_e               state_q, state_d;
    logic [1:0]           err_code_d;
    logic                 rd_wr_q;
    logic [ADD_LEN:0]     start_addr_q;
    logic [ADD_LEN-1:0]   num_words_q;
    logic [ADD_LEN-1:0]   remaining_q;
    logic [ADD_LEN-1:0]   pushed_q;
    logic [ADD_LEN-1:0]   rem_after_s;
    logic [TIMEOUT_W-1:0] wd_q;
    logic                 rqst_q, busy_q, done_q, err_q;
    logic [1:0]           err_code_q;

    logic                 accept_s, in_xfer_s, strobe_s;
    logic                 fifo_flush_s, fifo_push_s, fifo_pop_s;
    logic [DATA_LEN-1:0]  fifo_wdata_s, fifo_head_s;
    logic                 fifo_full_s, fifo_empty_s;
    logic [BUF_DEPTH:0]   fifo_used_s, fifo_free_s;
    logic                 rx_valid_s, tx_ready_s, tx_push_s, dev_ack_s;

    assign accept_s    = (state_q == ST_IDLE) && cfg_start;
    assign in_xfer_s   = (state_q == ST_XFER);
    // Strobes arriving after the last word are ignored rather than flagged.
    assign strobe_s    = in_xfer_s && dma_ack && (remaining_q != ADD_LEN'(0));
    assign rem_after_s = strobe_s ? (remaining_q - ADD_LEN'(1)) : remaining_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the word counted this cycle is included before end_flag is judged.
    always_comb begin
        state_d    = state_q;
        err_code_d = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (cfg_invalid(start_addr_q[0], num_words_q == ADD_LEN'(0))) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_CFG;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: state_d = ST_XFER;
            ST_XFER: begin
                if (end_flag) begin
                    if (rem_after_s == ADD_LEN'(0)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_SHORT;
                    end
                end else if (!dma_ack && (&wd_q)) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_DRAIN: begin
                if (!rd_wr_q || fifo_empty_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Buffer steering and handshakes; dev_ack keeps one free slot / one spare word for a late strobe.
    always_comb begin
        fifo_free_s  = (BUF_DEPTH+1)'(ENTRIES) - fifo_used_s;
        rx_valid_s   = rd_wr_q && !fifo_empty_s;
        tx_ready_s   = !rd_wr_q && in_xfer_s && !fifo_full_s && (pushed_q < num_words_q);
        tx_push_s    = tx_ready_s && tx_valid;
        fifo_flush_s = accept_s || (state_q == ST_ERR);
        if (rd_wr_q) begin
            fifo_push_s  = strobe_s;
            fifo_wdata_s = dev_out;
            fifo_pop_s   = rx_valid_s && rx_ready;
            dev_ack_s    = in_xfer_s && (fifo_free_s >= (BUF_DEPTH+1)'(2));
        end else begin
            fifo_push_s  = tx_push_s;
            fifo_wdata_s = tx_data;
            fifo_pop_s   = strobe_s;
            dev_ack_s    = in_xfer_s &&
                           ((fifo_used_s >= (BUF_DEPTH+1)'(2)) ||
                            ((fifo_used_s >= (BUF_DEPTH+1)'(1)) && (remaining_q == ADD_LEN'(1))));
        end
    end

    // Registered transfer parameters, counters and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rqst_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            rd_wr_q      <= 1'b0;
            start_addr_q <= '0;
            num_words_q  <= '0;
            remaining_q  <= '0;
            pushed_q     <= '0;
            wd_q         <= '0;
        end else begin
            rqst_q <= (state_d == ST_REQ) || (state_d == ST_XFER);
            busy_q <= (state_d != ST_IDLE);
            done_q <= (state_d == ST_DONE);
            if (accept_s) begin
                rd_wr_q      <= cfg_rd_wr;
                start_addr_q <= cfg_addr;
                num_words_q  <= cfg_words;
                remaining_q  <= cfg_words;
                pushed_q     <= '0;
                wd_q         <= '0;
                err_q        <= 1'b0;
                err_code_q   <= ERR_NONE;
            end else begin
                if (state_d == ST_ERR) begin
                    err_q      <= 1'b1;
                    err_code_q <= err_code_d;
                end
                if (in_xfer_s) begin
                    remaining_q <= rem_after_s;
                    wd_q        <= dma_ack ? TIMEOUT_W'(0) : (wd_q + TIMEOUT_W'(1));
                end
                if (tx_push_s) begin
                    pushed_q <= pushed_q + ADD_LEN'(1);
                end
            end
        end
    end

    dma_dev_agent_fifo #(
        .DATA_W  (DATA_LEN),
        .DEPTH_W (BUF_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .flush_i     (fifo_flush_s),
        .push_i      (fifo_push_s),
        .push_data_i (fifo_wdata_s),
        .pop_i       (fifo_pop_s),
        .head_o      (fifo_head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .used_o      (fifo_used_s)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign rqst       = rqst_q;
    assign rd_wr      = rd_wr_q;
    assign start_addr = start_addr_q;
    assign num_words  = num_words_q;
    assign rx_valid   = rx_valid_s;
    assign tx_ready   = tx_ready_s;
    assign dev_ack    = dev_ack_s;
    assign rx_data    = rx_valid_s ? fifo_head_s : DATA_LEN'(0);
    assign dev_in     = (!rd_wr_q && !fifo_empty_s) ? fifo_head_s : DATA_LEN'(0);

endmodule

// File: tb/tb_dma_dev_agent.sv
// Directed plus randomized bench for dma_dev_agent with a word-queue reference model
// standing in for both the DMA controller and the peripheral.
module tb_dma_dev_agent;
    localparam int AL = 16;
    localparam int DL = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_rd_wr = 1'b0;
    logic [AL:0]   cfg_addr = '0;
    logic [AL-1:0] cfg_words = '0;
    logic          busy, done, err;
    logic [1:0]    err_code;
    logic [DL-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [DL-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          rqst, rd_wr;
    logic [AL:0]   start_addr;
    logic [AL-1:0] num_words;
    logic          dev_ack;
    logic [DL-1:0] dev_in;
    logic          dma_ack = 1'b0;
    logic [DL-1:0] dev_out = '0;
    logic          end_flag = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [AL:0] ra;

    dma_dev_agent dut (
        .clk(clk), .reset(reset),
        .cfg_start(cfg_start), .cfg_rd_wr(cfg_rd_wr), .cfg_addr(cfg_addr), .cfg_words(cfg_words),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rqst(rqst), .rd_wr(rd_wr), .start_addr(start_addr), .num_words(num_words),
        .dev_ack(dev_ack), .dev_in(dev_in), .dma_ack(dma_ack), .dev_out(dev_out),
        .end_flag(end_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transfer: controller strobes on dev_ack (optionally one cycle late), peripheral
    // handshakes randomly; words are tracked in a queue in transfer order.
    task automatic run_xfer(input bit rd, input int n, input logic [AL:0] addr, input bit lag,
                            input int rdy_pct, input int end_at, input bit end_same,
                            input bit extra, input bit hold_rx, input bit stall,
                            input logic [1:0] exp_code);
        logic [DL-1:0] exp_q[$];
        logic [DL-1:0] w;
        int sent, pushed, delivered, done_cnt, rq_cyc, err_cyc, post, hold_cnt, occ;
        bit rq_seen, end_given, end_prev, extra_done, ack_prev, ack_now, err_seen;
        bit finished, released, rdy, exp_ack;
        sent = 0; pushed = 0; delivered = 0; done_cnt = 0; rq_cyc = 0; err_cyc = 0;
        post = 0; hold_cnt = 0; rq_seen = 0; end_given = 0; end_prev = 0; extra_done = 0;
        ack_prev = 0; err_seen = 0; finished = 0; released = 0;
        @(negedge clk);
        cfg_start = 1'b1; cfg_rd_wr = rd; cfg_addr = addr; cfg_words = AL'(n);
        @(negedge clk);
        cfg_start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_cleared", err, 0);
        for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
            if (rqst && !rq_seen) begin
                rq_seen = 1;
                check("start_addr", start_addr, addr);
                check("num_words", num_words, n);
                check("rd_wr", rd_wr, rd);
            end
            if (end_prev) check("rqst_fall", rqst, 0);
            if (done) done_cnt++;
            if (err && !err_seen) begin err_seen = 1; err_cyc = rq_cyc; end
            if (!rd && rqst && !end_given) begin
                occ = pushed - sent;
                exp_ack = (occ >= 2) || (occ >= 1 && (n - sent) == 1);
                check("dev_ack_wr", dev_ack, exp_ack);
            end
            if (rd) begin
                if (hold_rx && !released && ((sent - delivered) >= 4 || hold_cnt >= 30)) released = 1;
                if (hold_rx && !released) begin
                    rdy = 0; hold_cnt++;
                end else begin
                    rdy = ($urandom_range(99) < rdy_pct);
                end
                rx_ready = rdy;
                if (rx_valid && rdy) begin
                    if (exp_q.size() == 0) check("rx_unexpected", 1, 0);
                    else begin w = exp_q.pop_front(); check("rx_data", rx_data, w); end
                    delivered++;
                end
            end else begin
                if (rqst && pushed >= n) check("tx_ready_cap", tx_ready, 0);
                if (rq_seen && pushed < n && $urandom_range(99) < 60) begin
                    tx_valid = 1'b1; tx_data = DL'($urandom);
                    if (tx_ready) begin exp_q.push_back(tx_data); pushed++; end
                end else begin
                    tx_valid = 1'b0;
                end
            end
            ack_now = lag ? ack_prev : dev_ack;
            ack_prev = dev_ack;
            dma_ack = 1'b0; end_flag = 1'b0;
            if (!stall && rq_seen && !end_given) begin
                if (sent < end_at) begin
                    if (ack_now) begin
                        dma_ack = 1'b1; sent++;
                        if (rd) begin
                            dev_out = DL'($urandom); exp_q.push_back(dev_out);
                        end else if (exp_q.size() == 0) begin
                            check("dev_in_underflow", 1, 0);
                        end else begin
                            w = exp_q.pop_front(); check("dev_in", dev_in, w);
                        end
                        if (sent == end_at && end_same) begin end_flag = 1'b1; end_given = 1; end
                    end
                end else if (extra && !extra_done) begin
                    dma_ack = 1'b1; dev_out = DL'($urandom); extra_done = 1;
                end else begin
                    end_flag = 1'b1; end_given = 1;
                end
            end
            end_prev = end_flag;
            if (rq_seen) rq_cyc++;
            if (!busy && (end_given || err_seen)) post++;
            if (post >= 3) finished = 1;
            @(negedge clk);
        end
        dma_ack = 1'b0; end_flag = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0;
        check("finished_in_budget", finished, 1);
        if (exp_code == 2'b00) begin
            check("done_pulses", done_cnt, 1);
            check("err_ok", err, 0);
            check("queue_drained", exp_q.size(), 0);
            check("words_moved", sent, n);
            if (rd) check("dev_in_zero_rd", dev_in, 0);
        end else begin
            check("err_flag", err, 1);
            check("err_code", err_code, exp_code);
            check("no_done", done_cnt, 0);
            if (stall) check("wd_window", (err_cyc >= 4090 && err_cyc <= 4105), 1);
        end
    endtask

    task automatic bad_cfg(input logic [AL:0] addr, input int n);
        @(negedge clk);
        cfg_start = 1'b1; cfg_rd_wr = 1'b1; cfg_addr = addr; cfg_words = AL'(n);
        @(negedge clk);
        cfg_start = 1'b0;
        check("bad_err_cleared", err, 0);
        for (int i = 0; i < 8; i++) begin
            check("rqst_never", rqst, 0);
            @(negedge clk);
        end
        check("bad_err", err, 1);
        check("bad_code", err_code, 2'b01);
        check("bad_idle", busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ctrl", {busy, done, err, err_code, rx_valid, tx_ready, rqst, rd_wr, dev_ack}, 0);
        check("rst_addr", start_addr, 0);
        check("rst_words", num_words, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_dev_in", dev_in, 0);
        reset = 1'b1;
        @(negedge clk);

        run_xfer(1, 4, 17'h00200, 0, 100, 4, 0, 0, 0, 0, 2'b00);
        run_xfer(0, 3, 17'h00400, 0, 0, 3, 0, 0, 0, 0, 2'b00);
        run_xfer(1, 8, 17'h01000, 1, 100, 8, 0, 0, 1, 0, 2'b00);
        run_xfer(0, 1, 17'h00010, 0, 0, 1, 0, 0, 0, 0, 2'b00);
        run_xfer(1, 5, 17'h00020, 0, 70, 5, 0, 1, 0, 0, 2'b00);
        run_xfer(0, 6, 17'h00030, 0, 0, 6, 1, 0, 0, 0, 2'b00);
        run_xfer(0, 4, 17'h00032, 0, 0, 4, 0, 1, 0, 0, 2'b00);

        bad_cfg(17'h00200, 0);
        bad_cfg(17'h00101, 3);

        run_xfer(1, 5, 17'h00040, 0, 100, 2, 0, 0, 0, 0, 2'b10);
        run_xfer(1, 3, 17'h00050, 0, 100, 3, 0, 0, 0, 1, 2'b11);

        // Reset in the middle of a read transfer.
        @(negedge clk);
        cfg_start = 1'b1; cfg_rd_wr = 1'b1; cfg_addr = 17'h00300; cfg_words = 16'd8;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int i = 0; i < 10 && !rqst; i++) @(negedge clk);
        check("rqst_rise", rqst, 1);
        for (int i = 0; i < 3; i++) begin
            dma_ack = dev_ack; dev_out = DL'($urandom);
            @(negedge clk);
        end
        check("rqst_before_reset", rqst, 1);
        #2;
        reset = 1'b0; dma_ack = 1'b0;
        #1;
        check("mid_rst_ctrl", {busy, done, err, err_code, rx_valid, tx_ready, rqst, rd_wr, dev_ack}, 0);
        check("mid_rst_addr", start_addr, 0);
        check("mid_rst_rx_data", rx_data, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_xfer(1, 4, 17'h00060, 0, 100, 4, 0, 0, 0, 0, 2'b00);

        for (int k = 0; k < 5; k++) begin
            int rn;
            bit rrd;
            rn  = $urandom_range(10, 1);
            rrd = bit'($urandom_range(1));
            ra  = 17'($urandom);
            ra[0] = 1'b0;
            run_xfer(rrd, rn, ra, 0, $urandom_range(100, 30), rn,
                     bit'($urandom_range(1)), bit'($urandom_range(1)), 0, 0, 2'b00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
